// File: rtl/lemon_wb_pkg.sv
// rtl/lemon_wb_pkg.sv - shared writeback source-select and load-width encodings
package lemon_wb_pkg;

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_PC4  = 2'd2;
    localparam logic [1:0] SEL_ZERO = 2'd3;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/load_formatter.sv
// rtl/load_formatter.sv - extracts and extends a byte/halfword/word from a raw load word
module load_formatter
    import lemon_wb_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = rdata[{addr_lo, 3'b000} +: 8];
        half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LB:      data = {{24{byte_val[7]}}, byte_val};
            LBU:     data = {24'd0, byte_val};
            LH:      data = {{16{half_val[15]}}, half_val};
            LHU:     data = {16'd0, half_val};
            LW:      data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - 2-entry writeback FIFO with result formatting and pending-write hazard query
// Define WRITEBACK_TRACE_EN to print every register-file write in simulation.
module writeback_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [1:0]            in_sel,
    input  logic [DATA_WIDTH-1:0] in_alu,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_mem_rdata,
    input  logic [1:0]            in_addr_lo,
    input  logic [2:0]            in_funct3,
    input  logic                  wb_stall,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0] dataD,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  hit1,
    output logic                  hit2
);
    import lemon_wb_pkg::*;

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("writeback_unit: DATA_WIDTH must be 32");
    end

    logic [1:0]            count_q, count_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_mem_q [2];
    logic [ADDR_WIDTH-1:0] rd_mem_d [2];
    logic [DATA_WIDTH-1:0] data_mem_q [2];
    logic [DATA_WIDTH-1:0] data_mem_d [2];
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] push_data;
    logic [1:0]            entry_valid;
    logic                  push;
    logic                  pop;

    load_formatter u_load_formatter (
        .rdata   (in_mem_rdata),
        .addr_lo (in_addr_lo),
        .funct3  (in_funct3),
        .data    (load_data)
    );

    // Handshakes and writes are suppressed in the reset cycle so nothing leaks across it.
    assign in_ready = (count_q != 2'd2);
    assign push     = in_valid && in_ready && !rst;
    assign pop      = (count_q != 2'd0) && !wb_stall && !rst;

    always_comb begin
        case (in_sel)
            SEL_ALU:  push_data = in_alu;
            SEL_LOAD: push_data = load_data;
            SEL_PC4:  push_data = in_pc + DATA_WIDTH'(4);
            default:  push_data = '0;
        endcase
    end

    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        if (push) begin
            rd_mem_d[wr_ptr_q]   = in_rd;
            data_mem_d[wr_ptr_q] = push_data;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_mem_q   <= rd_mem_d;
        data_mem_q <= data_mem_d;
    end

    // An rd==0 entry still pops, but never raises the write enable.
    assign wen   = pop && (rd_mem_q[rd_ptr_q] != '0);
    assign rd    = pop ? rd_mem_q[rd_ptr_q] : '0;
    assign dataD = pop ? data_mem_q[rd_ptr_q] : '0;

    always_comb begin
        entry_valid = 2'b00;
        if (count_q == 2'd2) begin
            entry_valid = 2'b11;
        end else if (count_q == 2'd1) begin
            entry_valid[rd_ptr_q] = 1'b1;
        end
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (entry_valid[i] && (rd_mem_q[i] == rs1) && (rs1 != '0)) hit1 = 1'b1;
            if (entry_valid[i] && (rd_mem_q[i] == rs2) && (rs2 != '0)) hit2 = 1'b1;
        end
    end

`ifdef WRITEBACK_TRACE_EN
    always_ff @(posedge clk) begin
        if (wen) begin
            $display("writeback: x%0d <= 0x%08h", rd, dataD);
        end
    end
`else
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - self-checking bench for writeback_unit against a queue reference model
module tb_writeback_unit;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_rd = '0;
    logic [1:0]    in_sel = '0;
    logic [DW-1:0] in_alu = '0;
    logic [DW-1:0] in_pc = '0;
    logic [DW-1:0] in_mem_rdata = '0;
    logic [1:0]    in_addr_lo = '0;
    logic [2:0]    in_funct3 = '0;
    logic          wb_stall = 1'b0;
    logic          wen;
    logic [AW-1:0] rd;
    logic [DW-1:0] dataD;
    logic [AW-1:0] rs1 = '0;
    logic [AW-1:0] rs2 = '0;
    logic          hit1;
    logic          hit2;

    int vectors = 0;
    int miscompares = 0;

    logic [AW-1:0] m_rd[$];
    logic [DW-1:0] m_data[$];

    writeback_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_sel(in_sel), .in_alu(in_alu), .in_pc(in_pc),
        .in_mem_rdata(in_mem_rdata), .in_addr_lo(in_addr_lo), .in_funct3(in_funct3),
        .wb_stall(wb_stall), .wen(wen), .rd(rd), .dataD(dataD),
        .rs1(rs1), .rs2(rs2), .hit1(hit1), .hit2(hit2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_fmt(logic [1:0] sel, logic [31:0] alu, logic [31:0] pc,
                                            logic [31:0] rdata, logic [1:0] lo, logic [2:0] f3);
        logic [31:0] b;
        logic [31:0] h;
        b = (rdata >> (8 * lo)) & 32'hFF;
        h = (rdata >> (16 * lo[1])) & 32'hFFFF;
        if (sel == 2'd0) return alu;
        if (sel == 2'd2) return pc + 32'd4;
        if (sel == 2'd3) return 32'd0;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    function automatic bit exp_pop();
        return (m_rd.size() > 0) && !wb_stall && !rst;
    endfunction

    function automatic logic exp_wen();
        if (!exp_pop()) return 1'b0;
        return m_rd[0] != 0;
    endfunction

    function automatic logic [AW-1:0] exp_rd();
        if (!exp_pop()) return '0;
        return m_rd[0];
    endfunction

    function automatic logic [DW-1:0] exp_data();
        if (!exp_pop()) return '0;
        return m_data[0];
    endfunction

    function automatic logic exp_hit(logic [AW-1:0] rs);
        foreach (m_rd[i]) if (m_rd[i] == rs && rs != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input logic v, input logic [AW-1:0] r, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] rdata,
                         input logic [1:0] lo, input logic [2:0] f3);
        in_valid = v; in_rd = r; in_sel = sel; in_alu = alu; in_pc = pc;
        in_mem_rdata = rdata; in_addr_lo = lo; in_funct3 = f3;
    endtask

    task automatic advance();
        bit do_push;
        bit do_pop;
        logic [31:0] d;
        do_push = in_valid && (m_rd.size() < 2) && !rst;
        do_pop  = exp_pop();
        d = ref_fmt(in_sel, in_alu, in_pc, in_mem_rdata, in_addr_lo, in_funct3);
        @(posedge clk);
        if (rst) begin
            m_rd.delete();
            m_data.delete();
        end else begin
            if (do_pop) begin
                void'(m_rd.pop_front());
                void'(m_data.pop_front());
            end
            if (do_push) begin
                m_rd.push_back(in_rd);
                m_data.push_back(d);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, 2'd0, '0, '0, '0, '0, '0);
        advance();
        rst = 1'b0; rs1 = 5'd5; rs2 = 5'd6;
        #1;
        vectors += 6;
        if (wen !== 1'b0) begin miscompares++; $display("FAIL reset_wen got %b want 0", wen); end
        if (rd !== '0) begin miscompares++; $display("FAIL reset_rd got %0d want 0", rd); end
        if (dataD !== '0) begin miscompares++; $display("FAIL reset_data got %h want 0", dataD); end
        if (hit1 !== 1'b0) begin miscompares++; $display("FAIL reset_hit1 got %b want 0", hit1); end
        if (hit2 !== 1'b0) begin miscompares++; $display("FAIL reset_hit2 got %b want 0", hit2); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", in_ready); end
    endtask

    task automatic test_alu();
        drive(1'b1, 5'd5, 2'd0, 32'hDEADBEEF, '0, '0, '0, '0);
        advance();
        drive(1'b0, '0, 2'd0, '0, '0, '0, '0, '0);
        #1;
        vectors += 3;
        if (wen !== 1'b1) begin miscompares++; $display("FAIL alu_wen got %b want 1", wen); end
        if (rd !== 5'd5) begin miscompares++; $display("FAIL alu_rd got %0d want 5", rd); end
        if (dataD !== 32'hDEADBEEF) begin miscompares++; $display("FAIL alu_data got %h want deadbeef", dataD); end
        advance();
        vectors++;
        if (wen !== 1'b0) begin miscompares++; $display("FAIL alu_after_wen got %b want 0", wen); end
    endtask

    task automatic test_load();
        logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b101};
        logic [1:0]  los [3] = '{2'd3, 2'd3, 2'd2};
        logic [31:0] exps[3] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd9, 2'd1, '0, '0, 32'h80FF_0000, los[i], f3s[i]);
            advance();
            drive(1'b0, '0, 2'd0, '0, '0, '0, '0, '0);
            #1;
            vectors++;
            if (dataD !== exps[i] || wen !== 1'b1) begin
                miscompares++;
                $display("FAIL load_%0d got wen=%b data=%h want wen=1 data=%h", i, wen, dataD, exps[i]);
            end
            advance();
        end
    endtask

    task automatic test_pc4();
        drive(1'b1, 5'd3, 2'd2, '0, 32'hFFFFFFFC, '0, '0, '0);
        advance();
        drive(1'b0, '0, 2'd0, '0, '0, '0, '0, '0);
        #1;
        vectors++;
        if (wen !== 1'b1 || rd !== 5'd3 || dataD !== 32'h0) begin
            miscompares++;
            $display("FAIL pc4_wrap got wen=%b rd=%0d data=%h want 1/3/00000000", wen, rd, dataD);
        end
        advance();
    endtask

    task automatic test_stall();
        logic [1:0] ready_exp [3] = '{2'd1, 2'd1, 2'd0};
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(i + 1), 2'd0, $urandom, '0, '0, '0, '0);
            #1;
            vectors += 2;
            if (in_ready !== ready_exp[i][0]) begin
                miscompares++;
                $display("FAIL stall_ready_%0d got %b want %b", i, in_ready, ready_exp[i][0]);
            end
            if (wen !== 1'b0) begin miscompares++; $display("FAIL stall_wen_%0d got %b want 0", i, wen); end
            advance();
        end
        wb_stall = 1'b0;
        drive(1'b0, '0, 2'd0, '0, '0, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (wen !== exp_wen() || rd !== exp_rd() || dataD !== exp_data()
                || (i < 2 && rd !== 5'(i + 1)) || (i == 2 && wen !== 1'b0)) begin
                miscompares++;
                $display("FAIL stall_drain_%0d got wen=%b rd=%0d data=%h want wen=%b rd=%0d data=%h",
                         i, wen, rd, dataD, exp_wen(), exp_rd(), exp_data());
            end
            advance();
        end
    endtask

    task automatic test_rd0_hazard();
        drive(1'b1, 5'd0, 2'd0, 32'h1111_1111, '0, '0, '0, '0);
        advance();
        drive(1'b1, 5'd7, 2'd0, 32'h7777_7777, '0, '0, '0, '0);
        #1;
        vectors++;
        if (wen !== 1'b0) begin miscompares++; $display("FAIL rd0_wen got %b want 0", wen); end
        advance();
        drive(1'b0, '0, 2'd0, '0, '0, '0, '0, '0);
        rs1 = 5'd7; rs2 = 5'd0;
        #1;
        vectors += 3;
        if (wen !== 1'b1 || rd !== 5'd7 || dataD !== 32'h7777_7777) begin
            miscompares++;
            $display("FAIL rd7_write got wen=%b rd=%0d data=%h want 1/7/77777777", wen, rd, dataD);
        end
        if (hit1 !== 1'b1) begin miscompares++; $display("FAIL hit1_rs7 got %b want 1", hit1); end
        if (hit2 !== 1'b0) begin miscompares++; $display("FAIL hit2_rs0 got %b want 0", hit2); end
        rs1 = 5'd0;
        #1;
        vectors++;
        if (hit1 !== 1'b0) begin miscompares++; $display("FAIL hit1_rs0 got %b want 0", hit1); end
        advance();
    endtask

    task automatic test_reset_mid();
        wb_stall = 1'b1;
        drive(1'b1, 5'd9, 2'd0, 32'hA, '0, '0, '0, '0);
        advance();
        drive(1'b1, 5'd10, 2'd0, 32'hB, '0, '0, '0, '0);
        advance();
        rst = 1'b1; wb_stall = 1'b0; rs1 = 5'd9; rs2 = 5'd10;
        drive(1'b1, 5'd11, 2'd0, 32'hC, '0, '0, '0, '0);
        #1;
        vectors++;
        if (wen !== 1'b0) begin miscompares++; $display("FAIL rstmid_cycle_wen got %b want 0", wen); end
        advance();
        rst = 1'b0;
        drive(1'b0, '0, 2'd0, '0, '0, '0, '0, '0);
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors += 3;
            if (wen !== 1'b0) begin miscompares++; $display("FAIL rstmid_wen_%0d got %b want 0", i, wen); end
            if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready_%0d got %b want 1", i, in_ready); end
            if (hit1 !== 1'b0 || hit2 !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_hit_%0d got %b%b want 00", i, hit1, hit2);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 49) == 0);
            wb_stall = ($urandom_range(0, 2) == 0);
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            #1;
            vectors++;
            if (wen !== exp_wen() || rd !== exp_rd() || dataD !== exp_data() || in_ready !== (m_rd.size() < 2)
                || hit1 !== exp_hit(rs1) || hit2 !== exp_hit(rs2)) begin
                miscompares++;
                $display("FAIL random_%0d got wen=%b rd=%0d data=%h rdy=%b h=%b%b want wen=%b rd=%0d data=%h rdy=%b h=%b%b",
                         n, wen, rd, dataD, in_ready, hit1, hit2, exp_wen(), exp_rd(), exp_data(),
                         m_rd.size() < 2, exp_hit(rs1), exp_hit(rs2));
            end
            advance();
        end
        rst = 1'b0;
        wb_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_pc4();
        test_stall();
        test_rd0_hazard();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
